// File: rtl/fcvt_f2i_pipe_if.sv
// fcvt_f2i_pipe_if: handshake and data bundle for the float-to-int converter.
interface fcvt_f2i_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32
);
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_W+MAN_W:0]   in_op;
   logic [2:0]             in_rm;
   logic                   in_unsigned;
   logic                   out_valid;
   logic                   out_ready;
   logic [INT_W-1:0]       out_result;
   logic [4:0]             out_flags;
   logic                   busy;
   modport master (output flush, in_valid, in_op, in_rm, in_unsigned, out_ready,
                   input in_ready, out_valid, out_result, out_flags, busy);
   modport slave (input flush, in_valid, in_op, in_rm, in_unsigned, out_ready,
                  output in_ready, out_valid, out_result, out_flags, busy);
endinterface

// File: rtl/fcvt_f2i_pipe.sv
// fcvt_f2i_pipe: 3-stage float-to-int converter (decode, align, round/saturate)
// with RISC-V saturation, NV/NX flags and a valid/ready elastic pipeline.
module fcvt_f2i_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32
) (
   input logic            clk,
   input logic            reset_n,
   fcvt_f2i_pipe_if.slave io
);
   localparam int SW = INT_W + MAN_W + 3;
   localparam logic [EXP_W:0] BIAS = (EXP_W+1)'((1 << (EXP_W - 1)) - 1);
   localparam logic [INT_W:0] SMAX = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic [INT_W:0] SMIN = {2'b01, {(INT_W-1){1'b0}}};

   typedef struct packed {
      logic                    sign;
      logic signed [EXP_W:0]   e;
      logic [MAN_W:0]          sig;
      logic [2:0]              rm;
      logic                    uns;
      logic                    nan;
      logic                    inf;
   } s1_t;
   typedef struct packed {
      logic                    sign;
      logic [INT_W-1:0]        mag;
      logic                    g;
      logic                    r;
      logic                    s;
      logic                    of;
      logic [2:0]              rm;
      logic                    uns;
      logic                    nan;
   } s2_t;
   typedef struct packed {
      logic [INT_W-1:0]        res;
      logic [4:0]              flags;
   } s3_t;

   logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d, rdy1, rdy2, rdy3;
   s1_t s1_q, s1_d, dec;
   s2_t s2_q, s2_d, aln;
   s3_t s3_q, s3_d, rnd;
   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;
   int e_i;
   logic [SW-1:0] tmp;
   logic [INT_W-1:0] shl;
   logic [INT_W+1:0] shr;
   logic inc, nx, oor;
   logic [INT_W:0] mag1;

   assign rdy3 = !v3_q | io.out_ready;
   assign rdy2 = !v2_q | rdy3;
   assign rdy1 = !v1_q | rdy2;
   assign io.in_ready = rdy1;
   assign io.out_valid = v3_q;
   assign io.out_result = s3_q.res;
   assign io.out_flags = s3_q.flags;
   assign io.busy = v1_q | v2_q | v3_q;

   assign exp_f = io.in_op[EXP_W+MAN_W-1:MAN_W];
   assign man_f = io.in_op[MAN_W-1:0];
   always_comb begin
      dec.sign = io.in_op[EXP_W+MAN_W];
      dec.e = {1'b0, exp_f} - BIAS;
      dec.sig = {|exp_f, man_f};
      dec.rm = io.in_rm;
      dec.uns = io.in_unsigned;
      dec.nan = &exp_f & |man_f;
      dec.inf = &exp_f & ~|man_f;
   end

   // Two spare LSBs below the integer point carry guard and round out of the shifter.
   assign e_i = int'($signed(s1_q.e));
   assign tmp = {{INT_W{1'b0}}, s1_q.sig, 2'b00};
   always_comb begin
      aln.sign = s1_q.sign;
      aln.rm = s1_q.rm;
      aln.uns = s1_q.uns;
      aln.nan = s1_q.nan;
      aln.of = s1_q.inf | (e_i >= INT_W);
      aln.mag = '0;
      aln.g = 1'b0;
      aln.r = 1'b0;
      aln.s = 1'b0;
      shl = INT_W'(s1_q.sig) << (e_i - MAN_W);
      shr = (INT_W+2)'(tmp >> (MAN_W - e_i));
      if (!aln.of && e_i >= MAN_W) aln.mag = shl;
      else if (!aln.of && e_i >= -2) begin
         aln.mag = shr[INT_W+1:2];
         aln.g = shr[1];
         aln.r = shr[0];
         aln.s = |(tmp << (SW - MAN_W + e_i));
      end
      else if (!aln.of) aln.s = |s1_q.sig;
   end

   always_comb begin
      nx = s2_q.g | s2_q.r | s2_q.s;
      inc = (s2_q.rm == 3'd0) ? s2_q.g & (s2_q.r | s2_q.s | s2_q.mag[0]) :
            (s2_q.rm == 3'd2) ? s2_q.sign & nx :
            (s2_q.rm == 3'd3) ? ~s2_q.sign & nx :
            (s2_q.rm == 3'd4) ? s2_q.g : 1'b0;
      mag1 = {1'b0, s2_q.mag} + {{INT_W{1'b0}}, inc};
      oor = s2_q.of | (s2_q.uns ? (s2_q.sign ? |mag1 : mag1[INT_W])
                                : (mag1 > (s2_q.sign ? SMIN : SMAX)));
      rnd.res = s2_q.sign ? -mag1[INT_W-1:0] : mag1[INT_W-1:0];
      if (s2_q.nan | (~s2_q.sign & oor)) rnd.res = s2_q.uns ? '1 : SMAX[INT_W-1:0];
      else if (oor) rnd.res = s2_q.uns ? '0 : SMIN[INT_W-1:0];
      rnd.flags = (s2_q.nan | oor) ? 5'b10000 : {4'b0000, nx};
   end

   // Data loads are suppressed during flush so idle outputs keep their last value.
   always_comb begin
      v1_d = io.flush ? 1'b0 : rdy1 ? io.in_valid : v1_q;
      v2_d = io.flush ? 1'b0 : rdy2 ? v1_q : v2_q;
      v3_d = io.flush ? 1'b0 : rdy3 ? v2_q : v3_q;
      s1_d = (!io.flush & io.in_valid & rdy1) ? dec : s1_q;
      s2_d = (!io.flush & v1_q & rdy2) ? aln : s2_q;
      s3_d = (!io.flush & v2_q & rdy3) ? rnd : s3_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end
endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// tb_fcvt_f2i_pipe: directed vectors for rounding, saturation, specials,
// backpressure, flush and reset of the float-to-int pipeline.
module tb_fcvt_f2i_pipe;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;

   fcvt_f2i_pipe_if #(.EXP_W(8), .MAN_W(23), .INT_W(32)) io ();
   fcvt_f2i_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut (.clk(clk), .reset_n(reset_n), .io(io));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic conv(input string tag, input logic [31:0] op, input logic [2:0] rm,
                       input logic uns, input logic [31:0] er, input logic [4:0] ef);
      int n;
      io.out_ready = 1'b1;
      io.in_op = op;
      io.in_rm = rm;
      io.in_unsigned = uns;
      io.in_valid = 1'b1;
      #1;
      check({tag, "_rdy"}, io.in_ready, 1);
      tick;
      io.in_valid = 1'b0;
      n = 1;
      while (!io.out_valid && n < 10) begin
         tick;
         n++;
      end
      check({tag, "_lat"}, n, 3);
      check({tag, "_res"}, io.out_result, er);
      check({tag, "_flg"}, io.out_flags, ef);
      tick;
   endtask

   initial begin
      #200000;
      $fatal(1, "FAIL timeout");
   end

   initial begin
      logic [31:0] bp_op [6];
      int idx, got, blk, seen;
      logic acc, stall;
      logic [31:0] hv;
      bp_op = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
      io.flush = 1'b0;
      io.in_valid = 1'b0;
      io.in_op = '0;
      io.in_rm = 3'd0;
      io.in_unsigned = 1'b0;
      io.out_ready = 1'b1;
      tick;
      tick;
      check("rst_valid", io.out_valid, 0);
      check("rst_res", io.out_result, 0);
      check("rst_flg", io.out_flags, 0);
      check("rst_busy", io.busy, 0);
      reset_n = 1'b1;
      tick;

      conv("rne", 32'h40200000, 3'd0, 1'b0, 32'd2, 5'h01);
      conv("rtz", 32'h40200000, 3'd1, 1'b0, 32'd2, 5'h01);
      conv("rdn", 32'h40200000, 3'd2, 1'b0, 32'd2, 5'h01);
      conv("rup", 32'h40200000, 3'd3, 1'b0, 32'd3, 5'h01);
      conv("rmm", 32'h40200000, 3'd4, 1'b0, 32'd3, 5'h01);
      conv("rm7", 32'h40200000, 3'd7, 1'b0, 32'd2, 5'h01);
      conv("rne_up", 32'h40600000, 3'd0, 1'b0, 32'd4, 5'h01);
      conv("neg_rdn", 32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 5'h01);
      conv("s_2p31", 32'h4F000000, 3'd1, 1'b0, 32'h7FFFFFFF, 5'h10);
      conv("s_m2p31", 32'hCF000000, 3'd1, 1'b0, 32'h80000000, 5'h00);
      conv("s_mbig", 32'hCF000001, 3'd1, 1'b0, 32'h80000000, 5'h10);
      conv("u_2p31", 32'h4F000000, 3'd1, 1'b1, 32'h80000000, 5'h00);
      conv("u_2p32", 32'h4F800000, 3'd1, 1'b1, 32'hFFFFFFFF, 5'h10);
      conv("nan", 32'h7FC00000, 3'd1, 1'b0, 32'h7FFFFFFF, 5'h10);
      conv("ninf_u", 32'hFF800000, 3'd1, 1'b1, 32'h00000000, 5'h10);
      conv("sub_rup", 32'h00000001, 3'd3, 1'b0, 32'd1, 5'h01);
      conv("u_m03_rtz", 32'hBE99999A, 3'd1, 1'b1, 32'd0, 5'h01);
      conv("u_m03_rdn", 32'hBE99999A, 3'd2, 1'b1, 32'd0, 5'h10);
      conv("u_m1", 32'hBF800000, 3'd1, 1'b1, 32'd0, 5'h10);
      conv("nzero_u", 32'h80000000, 3'd0, 1'b1, 32'd0, 5'h00);

      idx = 0;
      got = 0;
      blk = -1;
      io.in_rm = 3'd1;
      io.in_unsigned = 1'b0;
      for (int c = 1; c < 40 && got < 6; c++) begin
         io.out_ready = !(c >= 2 && c <= 7);
         io.in_valid = idx < 6;
         io.in_op = bp_op[idx < 6 ? idx : 5];
         #1;
         if (io.in_valid && !io.in_ready && blk < 0) blk = idx;
         if (io.out_valid && io.out_ready) begin
            check("bp_res", io.out_result, 32'(got + 1));
            got++;
         end
         stall = io.out_valid & !io.out_ready;
         hv = io.out_result;
         acc = io.in_valid & io.in_ready;
         tick;
         if (acc) idx++;
         if (stall) begin
            check("bp_hold_v", io.out_valid, 1);
            check("bp_hold_r", io.out_result, hv);
         end
      end
      check("bp_first_block", blk, 3);
      check("bp_count", got, 6);
      check("bp_accepted", idx, 6);
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      seen = 0;
      repeat (4) begin
         seen += int'(io.out_valid);
         tick;
      end
      check("bp_no_dup", seen, 0);

      io.in_valid = 1'b1;
      io.in_op = 32'h3F800000;
      tick;
      io.in_op = 32'h40000000;
      tick;
      io.in_op = 32'h40400000;
      io.flush = 1'b1;
      #1;
      check("fl_rdy", io.in_ready, 1);
      check("fl_busy_pre", io.busy, 1);
      tick;
      io.flush = 1'b0;
      io.in_valid = 1'b0;
      check("fl_busy", io.busy, 0);
      seen = 0;
      repeat (6) begin
         seen += int'(io.out_valid);
         tick;
      end
      check("fl_none", seen, 0);
      conv("fl_next", 32'h40A00000, 3'd1, 1'b0, 32'd5, 5'h00);

      io.in_rm = 3'd1;
      io.in_valid = 1'b1;
      io.in_op = 32'h3F800000;
      tick;
      io.in_op = 32'h40000000;
      tick;
      io.in_op = 32'h40400000;
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      io.in_valid = 1'b0;
      check("rs_valid", io.out_valid, 0);
      check("rs_res", io.out_result, 0);
      check("rs_flg", io.out_flags, 0);
      check("rs_busy", io.busy, 0);
      seen = 0;
      repeat (6) begin
         seen += int'(io.out_valid);
         tick;
      end
      check("rs_none", seen, 0);
      conv("rs_next", 32'h40C00000, 3'd1, 1'b0, 32'd6, 5'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
